// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int          FQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [29:0] START_ADDR       = 30'h0000BFF;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem_r [DEPTH];

  // Write port; contents need no reset because they are only read while valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch FIFO between the PC/fetch stage and decode; back-pressures fetch via pc_write.
// Optional performance counters are enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int PC_W  = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            in_valid,
  output logic            pc_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          enq_s;
  logic          deq_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  rd_entry_s;

  // Everything visible to fetch/decode is decoded from registered state only.
  assign full_s    = (count_r == CW'(DEPTH));
  assign pc_write  = !full_s;
  assign out_valid = (count_r != '0);
  assign enq_s     = in_valid && pc_write && !flush;
  assign deq_s     = out_valid && out_ready && !flush;

  assign wr_entry_s.pc    = pc_in;
  assign wr_entry_s.instr = instr_in;

  fetch_queue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (enq_s),
    .waddr(wr_ptr_r),
    .wdata(wr_entry_s),
    .raddr(rd_ptr_r),
    .rdata(rd_entry_s)
  );

  // Head presentation: decode sees a NOP whenever the queue is empty.
  always_comb begin
    out_pc    = rd_entry_s.pc;
    out_instr = NOP_INSTR;
    if (out_valid) begin
      out_instr = rd_entry_s.instr;
    end else begin
      out_instr = NOP_INSTR;
    end
  end

  // Pointer and occupancy update; flush wins over any same-cycle transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (in_valid && !pc_write) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (flush) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random vs. queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] pc_in;
  logic [31:0] instr_in;
  logic        in_valid;
  logic        pc_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .PC_W(30)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .instr_in (instr_in),
    .in_valid (in_valid),
    .pc_write (pc_write),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          iv;
    bit          rdy;
    bit          fl;
    logic [29:0] pc;
    logic [31:0] instr;
    bit          e_valid;
    logic [29:0] e_pc;
    logic [31:0] e_instr;
    bit          e_pw;
  } vec_t;

  ent_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_out(string tag, bit ev, logic [29:0] ep, logic [31:0] ei, bit epw);
    cmp({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) cmp({tag, ".out_pc"}, {2'b00, out_pc}, {2'b00, ep});
    cmp({tag, ".out_instr"}, out_instr, ei);
    cmp({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, epw});
  endtask

  task automatic check_model(string tag);
    bit ev;
    ev = (mq.size() != 0);
    check_out(tag, ev, ev ? mq[0].pc : 30'd0, ev ? mq[0].instr : 32'd0, mq.size() < DEPTH);
`ifdef FETCH_QUEUE_PERF_EN
    cmp({tag, ".stall_cnt"}, stall_cnt, m_stall);
    cmp({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  // Apply one cycle of inputs, advance the reference queue, sample 1 time unit after the edge.
  task automatic step(bit iv, logic [29:0] pc, logic [31:0] instr, bit rdy, bit fl);
    bit was_full, was_empty;
    in_valid = iv; pc_in = pc; instr_in = instr; out_ready = rdy; flush = fl;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (iv && was_full) m_stall = m_stall + 32'd1;
    if (fl) m_flush = m_flush + 32'd1;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy && !was_empty) void'(mq.pop_front());
      if (iv && !was_full) mq.push_back({pc, instr});
    end
    #1;
  endtask

  vec_t vt[10];

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    pc_in = 30'd0; instr_in = 32'd0;
    #12;
    check_out("reset", 1'b0, 30'd0, 32'd0, 1'b1);
`ifdef FETCH_QUEUE_PERF_EN
    cmp("reset.stall_cnt", stall_cnt, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // iv rdy fl pc instr | valid pc instr pc_write
    vt[0] = '{1, 0, 0, 30'h0000BFF, 32'h2008_0001, 1, 30'h0000BFF, 32'h2008_0001, 1};
    vt[1] = '{1, 0, 0, 30'h101, 32'h1000_0101, 1, 30'h0000BFF, 32'h2008_0001, 1};
    vt[2] = '{1, 0, 0, 30'h102, 32'h1000_0102, 1, 30'h0000BFF, 32'h2008_0001, 1};
    vt[3] = '{1, 0, 0, 30'h103, 32'h1000_0103, 1, 30'h0000BFF, 32'h2008_0001, 0};
    vt[4] = '{1, 0, 0, 30'h104, 32'h1000_0104, 1, 30'h0000BFF, 32'h2008_0001, 0};
    vt[5] = '{0, 1, 0, 30'h0,   32'h0,         1, 30'h101,     32'h1000_0101, 1};
    vt[6] = '{1, 1, 0, 30'h105, 32'h1000_0105, 1, 30'h102,     32'h1000_0102, 1};
    vt[7] = '{1, 1, 1, 30'h106, 32'h1000_0106, 0, 30'h0,       32'h0,         1};
    vt[8] = '{1, 1, 0, 30'h200, 32'h1000_0200, 1, 30'h200,     32'h1000_0200, 1};
    vt[9] = '{0, 1, 0, 30'h0,   32'h0,         0, 30'h0,       32'h0,         1};
    for (int i = 0; i < 10; i++) begin
      step(vt[i].iv, vt[i].pc, vt[i].instr, vt[i].rdy, vt[i].fl);
      check_out($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_pc, vt[i].e_instr, vt[i].e_pw);
    end
`ifdef FETCH_QUEUE_PERF_EN
    cmp("vec.stall_cnt", stall_cnt, 32'd1);
    cmp("vec.flush_cnt", flush_cnt, 32'd1);
`endif

    // Fill to DEPTH then drain: order must be preserved.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 30'h100 + 30'(i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cmp($sformatf("drain%0d.pc", i), {2'b00, out_pc}, 32'h100 + 32'(i));
      step(1'b0, 30'd0, 32'd0, 1'b1, 1'b0);
    end
    check_model("drained");

    // Steady count=2 with simultaneous push/pop across pointer wrap.
    step(1'b1, 30'h300, 32'hA000_0300, 1'b0, 1'b0);
    step(1'b1, 30'h301, 32'hA000_0301, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 30'h302 + 30'(i), 32'hA000_0302 + 32'(i), 1'b1, 1'b0);
      check_model($sformatf("wrap%0d", i));
      cmp($sformatf("wrap%0d.size", i), 32'(mq.size()), 32'd2);
    end

    // Flush at count=3 with a fetch in the same cycle.
    step(1'b1, 30'h400, 32'hB000_0400, 1'b0, 1'b0);
    step(1'b1, 30'h401, 32'hB000_0401, 1'b1, 1'b1);
    check_out("flush", 1'b0, 30'd0, 32'd0, 1'b1);
    step(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
    check_out("flush_nostore", 1'b0, 30'd0, 32'd0, 1'b1);

    // Asynchronous reset between edges at count=2.
    step(1'b1, 30'h500, 32'hD000_0500, 1'b0, 1'b0);
    step(1'b1, 30'h501, 32'hD000_0501, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_out("async_rst", 1'b0, 30'd0, 32'd0, 1'b1);
    mq.delete(); m_stall = 32'd0; m_flush = 32'd0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 30'h600, 32'hE000_0600, 1'b0, 1'b0);
    check_out("post_rst", 1'b1, 30'h600, 32'hE000_0600, 1'b1);

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 30'($urandom), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of buffered fetch entries, power of two, range 2..16.
REQ-002 SHALL have parameter PC_W, default 30; width of the word-address PC field [31:2].
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc_in  input  30  word address [31:2] of the fetched instruction, taken from the PC register.
REQ-006 instr_in  input  32  fetched instruction word for pc_in.
REQ-007 in_valid  input  1  pc_in/instr_in hold a valid fetch this cycle.
REQ-008 pc_write  output  1  drives PCWrite of the PC register; 1 = PC may advance, 0 = stall fetch.
REQ-009 flush  input  1  branch/jump redirect; discard all buffered and incoming fetches.
REQ-010 out_valid  output  1  head entry presented to decode.
REQ-011 out_ready  input  1  decode accepts the head entry.
REQ-012 out_pc  output  30  word address of the head entry.
REQ-013 out_instr  output  32  instruction of the head entry; 32'h0000_0000 (NOP) when out_valid=0.

Function
REQ-014 SHALL be a circular FIFO with read pointer, write pointer and count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-015 pc_write SHALL be 1 when count<DEPTH and 0 when count==DEPTH; it is decoded from registered count only, with no combinational path from out_ready or in_valid.
REQ-016 Enqueue SHALL occur when in_valid && pc_write && !flush; the entry is written at the write pointer on that edge.
REQ-017 Dequeue SHALL occur when out_valid && out_ready && !flush.
REQ-018 Enqueue and dequeue in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-019 When full, in_valid SHALL be ignored even if a dequeue occurs that cycle; there is no bypass into a full queue.
REQ-020 Output latency SHALL be one cycle: an entry enqueued into an empty queue at edge N shows out_valid=1 after edge N.
REQ-021 out_valid SHALL equal (count!=0); out_pc/out_instr SHALL be driven from the entry at the read pointer.
REQ-022 flush SHALL, at the next edge, set count=0 and both pointers to 0, and drop any same-cycle enqueue or dequeue.
REQ-023 Entries SHALL leave the queue in exactly the order they were enqueued; no duplication or loss except on flush.

Reset
REQ-024 While reset=0: count=0, pointers=0, out_valid=0, out_instr=NOP, pc_write=1.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).
REQ-026 Storage contents SHALL need no reset; they are unobservable while out_valid=0.

Configuration
REQ-027 Macro FETCH_QUEUE_PERF_EN SHALL control the performance counters.
REQ-028 With FETCH_QUEUE_PERF_EN defined:
  - add 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle with in_valid && !pc_write.
  - flush_cnt increments each cycle with flush=1.
  - both counters reset to 0 and wrap at 2^32.
REQ-029 With FETCH_QUEUE_PERF_EN undefined: the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold:
  - FQ_DEPTH_DEFAULT = 4.
  - NOP_INSTR = 32'h0000_0000.
  - START_ADDR = 30'h0000BFF.
  - struct fetch_entry_t {pc[29:0], instr[31:0]}.
REQ-031 Storage SHALL be a sub-module fetch_queue_mem (DEPTH x fetch_entry_t, 1 write port, 1 asynchronous read port); pointers and control stay in fetch_queue.

Verification
REQ-032 After reset, enqueue pc 0x0000BFF / instr 0x2008_0001 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0000BFF, out_instr=0x2008_0001, pc_write=1.
REQ-033 With out_ready=0, enqueue 4 entries (pc 0x100..0x103) -> pc_write=0 after the 4th edge; a 5th in_valid is dropped and stall_cnt increments (PERF_EN); draining yields 0x100..0x103 in order.
REQ-034 Queue at count=2, then in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap, output order matches input order.
REQ-035 Queue at count=3 with in_valid=1, then flush=1 -> next cycle out_valid=0, out_instr=0, pc_write=1, and the flush-cycle fetch is not stored.
REQ-036 Queue at count=2, then reset=0 between edges -> out_valid=0 and pc_write=1 immediately; after release, the first enqueue appears at the head.
